instruction_fetch_unit: RTL and testbench

// Fetch stage between program memory and decode/execute. Drives the program-memory

---
 rtl/instruction_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetch stage between a combinational program memory and the
//            decode stage. Walks the PC one byte per clock, assembles each
//            3-byte instruction (opcode, operand, register select) and offers
//            it downstream over a valid/ready handshake. Supports a jump
//            redirect and a halt opcode that stops fetching.
// Ports    : clk        - clock, rising-edge state updates
//            rst_n      - synchronous active-low reset
//            pm_addr    - program-memory address (current PC)
//            pm_data    - program-memory byte at pm_addr (same cycle)
//            jump_en    - redirect PC to jump_addr this cycle
//            jump_addr  - redirect target
//            ir_valid   - assembled instruction is valid
//            ir_ready   - downstream accepts the instruction
//            ir_opcode  - byte 0
//            ir_operand - byte 1 (immediate)
//            ir_reg     - byte 2 (register select)
//            ir_pc      - address of byte 0
//            halted     - fetch stopped after a halt opcode was transferred
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [DATA_W-1:0] HLT_OP   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_opcode,
    output logic [DATA_W-1:0] ir_operand,
    output logic [DATA_W-1:0] ir_reg,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] c_pc_inc = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        F_OP  = 3'd0,
        F_OPD = 3'd1,
        F_REG = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] r_opcode;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_reg;
    logic [ADDR_W-1:0] r_ir_pc;

    // ------------------------------------------------------------------------
    // Next-state / next-PC logic. A jump overrides all fetch progress; a
    // bundle handed over in the same cycle as a jump is simply considered
    // consumed, so no extra handling is needed for that case.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        if (jump_en) begin
            w_next_state = F_OP;
            w_pc_next    = jump_addr;
        end else begin
            case (r_state)
                F_OP: begin
                    w_next_state = F_OPD;
                    w_pc_next    = r_pc + c_pc_inc;
                end
                F_OPD: begin
                    w_next_state = F_REG;
                    w_pc_next    = r_pc + c_pc_inc;
                end
                F_REG: begin
                    w_next_state = HOLD;
                    w_pc_next    = r_pc + c_pc_inc;
                end
                HOLD: begin
                    if (ir_ready) begin
                        w_next_state = (r_opcode == HLT_OP) ? HALT : F_OP;
                    end
                end
                HALT: begin
                    w_next_state = HALT;
                end
                default: begin
                    w_next_state = F_OP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, PC and instruction-field registers. Fields are written only in
    // the three fetch states, so they stay frozen while the bundle is offered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= F_OP;
            r_pc      <= RESET_PC;
            r_opcode  <= '0;
            r_operand <= '0;
            r_reg     <= '0;
            r_ir_pc   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (!jump_en) begin
                case (r_state)
                    F_OP: begin
                        r_opcode <= pm_data;
                        r_ir_pc  <= r_pc;
                    end
                    F_OPD: begin
                        r_operand <= pm_data;
                    end
                    F_REG: begin
                        r_reg <= pm_data;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign pm_addr    = r_pc;
    assign ir_valid   = (r_state == HOLD);
    assign halted     = (r_state == HALT);
    assign ir_opcode  = r_opcode;
    assign ir_operand = r_operand;
    assign ir_reg     = r_reg;
    assign ir_pc      = r_ir_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed bench for instruction_fetch_unit: a vector table for the
//            basic fetch/backpressure stream, then hand-written sequences for
//            jump abort, PC wrap, halt and mid-instruction reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_opcode;
    logic [7:0] ir_operand;
    logic [7:0] ir_reg;
    logic [7:0] ir_pc;
    logic       halted;

    logic [7:0] pm [0:255];
    assign pm_data = pm[pm_addr];

    int n_checks = 0;
    int n_err    = 0;

    instruction_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .RESET_PC (8'h00),
        .HLT_OP   (8'hFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pm_addr    (pm_addr),
        .pm_data    (pm_data),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_reg     (ir_reg),
        .ir_pc      (ir_pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       jump_en;
        logic [7:0] jump_addr;
        logic       ready;
        logic       v;
        logic [7:0] op;
        logic [7:0] opd;
        logic [7:0] rg;
        logic [7:0] ipc;
        logic [7:0] pa;
        logic       h;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [7:0] op,
                           input logic [7:0] opd, input logic [7:0] rg,
                           input logic [7:0] ipc, input logic [7:0] pa, input logic h);
        chk({tag, ".valid"},   {7'd0, ir_valid}, {7'd0, v});
        chk({tag, ".opcode"},  ir_opcode,  op);
        chk({tag, ".operand"}, ir_operand, opd);
        chk({tag, ".reg"},     ir_reg,     rg);
        chk({tag, ".ir_pc"},   ir_pc,      ipc);
        chk({tag, ".pm_addr"}, pm_addr,    pa);
        chk({tag, ".halted"},  {7'd0, halted}, {7'd0, h});
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) pm[a] = 8'hEE;
        pm[8'h00] = 8'h01; pm[8'h01] = 8'h07; pm[8'h02] = 8'h02;
        pm[8'h03] = 8'h03; pm[8'h04] = 8'h04; pm[8'h05] = 8'h05;
        pm[8'h06] = 8'h66;
        pm[8'h10] = 8'h31; pm[8'h11] = 8'h32; pm[8'h12] = 8'h33;
        pm[8'h40] = 8'h11; pm[8'h41] = 8'h22; pm[8'h42] = 8'h33;
        pm[8'hFE] = 8'hAA; pm[8'hFF] = 8'hBB;

        //          rst  jmp addr   rdy    v  op     opd    reg    ir_pc  pm_addr halted
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h07, 8'h00, 8'h00, 8'h02, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h07, 8'h02, 8'h03, 8'h04, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h04, 8'h02, 8'h03, 8'h05, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h04, 8'h05, 8'h03, 8'h06, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h04, 8'h05, 8'h03, 8'h06, 1'b0};

        rst_n = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; ir_ready = 1'b1;
        #1;

        // Basic fetch, 5-clock backpressure, second instruction
        for (int i = 0; i < 14; i++) begin
            rst_n     = tbl[i].rst_n;
            jump_en   = tbl[i].jump_en;
            jump_addr = tbl[i].jump_addr;
            ir_ready  = tbl[i].ready;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].op, tbl[i].opd,
                    tbl[i].rg, tbl[i].ipc, tbl[i].pa, tbl[i].h);
        end

        // Jump during F_OPD: operand never captured, bundle comes from 0x40
        step();
        chk_all("jmp_fop", 1'b0, 8'h66, 8'h04, 8'h05, 8'h06, 8'h07, 1'b0);
        jump_en = 1'b1; jump_addr = 8'h40;
        step();
        chk_all("jmp_redirect", 1'b0, 8'h66, 8'h04, 8'h05, 8'h06, 8'h40, 1'b0);
        jump_en = 1'b0;
        step();
        chk_all("jmp_b0", 1'b0, 8'h11, 8'h04, 8'h05, 8'h40, 8'h41, 1'b0);
        step();
        chk_all("jmp_b1", 1'b0, 8'h11, 8'h22, 8'h05, 8'h40, 8'h42, 1'b0);
        step();
        chk_all("jmp_bundle", 1'b1, 8'h11, 8'h22, 8'h33, 8'h40, 8'h43, 1'b0);
        step();
        chk_all("jmp_xfer", 1'b0, 8'h11, 8'h22, 8'h33, 8'h40, 8'h43, 1'b0);

        // Wrap: instruction at FE straddles FF -> 00
        jump_en = 1'b1; jump_addr = 8'hFE;
        step();
        chk_all("wrap_redirect", 1'b0, 8'h11, 8'h22, 8'h33, 8'h40, 8'hFE, 1'b0);
        jump_en = 1'b0;
        step();
        step();
        chk("wrap_pm_addr_00", pm_addr, 8'h00);
        step();
        chk_all("wrap_bundle", 1'b1, 8'hAA, 8'hBB, 8'h01, 8'hFE, 8'h01, 1'b0);
        step();
        chk_all("wrap_xfer", 1'b0, 8'hAA, 8'hBB, 8'h01, 8'hFE, 8'h01, 1'b0);

        // Halt opcode at address 0
        pm[8'h00] = 8'hFF; pm[8'h01] = 8'h5A; pm[8'h02] = 8'h5B;
        rst_n = 1'b0;
        step();
        chk_all("halt_reset", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        step(); step(); step();
        chk_all("halt_bundle", 1'b1, 8'hFF, 8'h5A, 8'h5B, 8'h00, 8'h03, 1'b0);
        step();
        chk_all("halt_enter", 1'b0, 8'hFF, 8'h5A, 8'h5B, 8'h00, 8'h03, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step();
            chk_all($sformatf("halt_hold%0d", c), 1'b0, 8'hFF, 8'h5A, 8'h5B, 8'h00, 8'h03, 1'b1);
        end
        jump_en = 1'b1; jump_addr = 8'h10;
        step();
        chk_all("halt_exit", 1'b0, 8'hFF, 8'h5A, 8'h5B, 8'h00, 8'h10, 1'b0);
        jump_en = 1'b0;
        step(); step(); step();
        chk_all("halt_resume", 1'b1, 8'h31, 8'h32, 8'h33, 8'h10, 8'h13, 1'b0);
        step();
        chk_all("halt_resume_xfer", 1'b0, 8'h31, 8'h32, 8'h33, 8'h10, 8'h13, 1'b0);

        // Reset in F_REG, then reset in HOLD under backpressure
        pm[8'h00] = 8'h01; pm[8'h01] = 8'h07; pm[8'h02] = 8'h02;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step();
        chk_all("rst_pre_freg", 1'b0, 8'h01, 8'h07, 8'h00, 8'h00, 8'h02, 1'b0);
        rst_n = 1'b0;
        step();
        chk_all("rst_in_freg", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1; ir_ready = 1'b0;
        step(); step(); step();
        chk_all("rst_refetch", 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0);
        step();
        chk_all("rst_hold_bp", 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0);
        rst_n = 1'b0;
        step();
        chk_all("rst_in_hold", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        step(); step(); step();
        chk_all("rst_refetch2", 1'b1, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0);
        ir_ready = 1'b1;
        step();
        chk_all("rst_xfer", 1'b0, 8'h01, 8'h07, 8'h02, 8'h00, 8'h03, 1'b0);
        step();
        chk_all("rst_next_fop", 1'b0, 8'h03, 8'h07, 8'h02, 8'h03, 8'h04, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
